// File: rtl/dlx_fetch_pkg.sv
// Shared types for the DLX instruction-fetch unit: FSM states, fetch-buffer entry, PC step.
package dlx_fetch_pkg;

    localparam int FETCH_PC_W    = 32;
    localparam int FETCH_WORD_W  = 32;
    localparam int FETCH_PC_STEP = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FLUSH = 2'd1,
        ERROR = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]   pc;
        logic [FETCH_WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/dlx_fetch_fifo.sv
// Small synchronous fetch buffer between the memory response path and decode.
module fetch_fifo
    import dlx_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: storage is not reset; count gates every read, so stale slots are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            slots[wr_ptr] <= push_entry;
        end
    end

    // DEPTH is a power of two, so plain increments wrap the pointers for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = slots[rd_ptr];

endmodule

// File: rtl/dlx_fetch_unit.sv
// DLX instruction-fetch initiator: issues word reads to instruction memory and queues
// returned words with their byte PC toward decode; redirects restart the stream.
module dlx_fetch_unit
    import dlx_fetch_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned ADDRESS_SIZE = 16,
    parameter int unsigned PC_WIDTH     = 32,
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned MAX_WAIT     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    mem_enable,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    input  logic [WORD_SIZE-1:0]    mem_data,
    input  logic                    mem_data_ready,
    input  logic                    redirect_valid,
    input  logic [PC_WIDTH-1:0]     redirect_pc,
    output logic                    ir_valid,
    input  logic                    ir_ready,
    output logic [WORD_SIZE-1:0]    ir_data,
    output logic [PC_WIDTH-1:0]     ir_pc,
    output logic                    fetch_err
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    fetch_state_t      state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] req_pc;
    logic              inflight;
    logic [WAIT_W-1:0] wait_cnt;

    logic              in_fetch;
    logic              response;
    logic              waiting;
    logic              credit;
    logic              issue;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    occupancy;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;
    logic              unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    // Credit counts the outstanding request as already occupying a slot; a pop in the
    // same cycle is deliberately not credited so the check uses registered state only.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign credit    = occupancy < (CNT_W + 1)'(FIFO_DEPTH);

    assign in_fetch = (state == FETCH) && !redirect_valid;
    assign response = in_fetch && inflight && mem_data_ready;
    assign waiting  = in_fetch && inflight && !mem_data_ready;
    assign issue    = in_fetch && (!inflight || mem_data_ready) && credit;

    // Enable is gated by rst so the port reads 0 the moment reset asserts.
    assign mem_enable  = rst && (issue || waiting);
    assign mem_address = issue ? pc[ADDRESS_SIZE+1:2] : req_pc[ADDRESS_SIZE+1:2];

    assign push             = response;
    assign pop              = ir_valid && ir_ready && !redirect_valid;
    assign push_entry.pc    = FETCH_PC_W'(req_pc);
    assign push_entry.instr = FETCH_WORD_W'(mem_data);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .count      (count)
    );

    assign ir_valid = (count != '0);
    assign ir_data  = ir_valid ? WORD_SIZE'(head.instr) : '0;
    assign ir_pc    = ir_valid ? PC_WIDTH'(head.pc) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            pc        <= PC_WIDTH'(RESET_PC);
            req_pc    <= '0;
            inflight  <= 1'b0;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else if (redirect_valid) begin
            state     <= FLUSH;
            pc        <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
            inflight  <= 1'b0;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (waiting) begin
                        if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                            state     <= ERROR;
                            fetch_err <= 1'b1;
                            inflight  <= 1'b0;
                            wait_cnt  <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                    if (response) begin
                        wait_cnt <= '0;
                        inflight <= 1'b0;
                    end
                    // A re-issue in the response cycle keeps inflight set.
                    if (issue) begin
                        req_pc   <= pc;
                        pc       <= pc + PC_WIDTH'(FETCH_PC_STEP);
                        inflight <= 1'b1;
                    end
                end
                // One idle cycle with enable low lets memory drop DATA_READY.
                FLUSH:   state <= FETCH;
                ERROR:   state <= ERROR;
                default: state <= FETCH;
            endcase
        end
    end

endmodule
